// File: rtl/uop_queue_if.sv
// Handshake bundle between decode (enqueue side) and execute dispatch (dequeue side) for uop_queue.
interface uop_queue_if #(
    parameter int DATA_W = 100
);
    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_uop;
    logic              deq_valid;
    logic              deq_ready;
    logic [DATA_W-1:0] deq_uop;

    modport master (
        output enq_valid, enq_uop, deq_ready,
        input  enq_ready, deq_valid, deq_uop
    );

    modport slave (
        input  enq_valid, enq_uop, deq_ready,
        output enq_ready, deq_valid, deq_uop
    );
endinterface

// File: rtl/uop_queue.sv
// In-order uop buffer between decode and execute, with flush and wrap-flag head/tail pointers.
// Optional same-cycle empty-queue bypass enabled by defining UOP_QUEUE_BYPASS_EN.
module uop_queue #(
    parameter int DEPTH = 4,
    parameter int DATA_W = 100,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    uop_queue_if.slave     q,
    output logic [IDX_W:0] count
);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W:0] PTR_ONE = CNT_W'(1);

    logic [IDX_W:0]    head_q, head_d;
    logic [IDX_W:0]    tail_q, tail_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  head_idx;
    logic [IDX_W-1:0]  tail_idx;
    logic              empty;
    logic              full;
    logic              bypass;
    logic              enq_fire;
    logic              deq_fire;
    logic              wr_en;
    logic              head_adv;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign empty    = (head_idx == tail_idx) && (head_q[IDX_W] == tail_q[IDX_W]);
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    // enq_ready deliberately ignores deq_ready so no ready->ready combinational path exists
    assign q.enq_ready = !full && !flush && !reset;

`ifdef UOP_QUEUE_BYPASS_EN
    assign bypass = empty && q.enq_valid && !flush && !reset;
`else
    assign bypass = 1'b0;
`endif

    assign q.deq_valid = (!empty && !flush && !reset) || bypass;
    assign q.deq_uop   = bypass ? q.enq_uop : mem_q[head_idx];

    assign enq_fire = q.enq_valid && q.enq_ready;
    assign deq_fire = q.deq_valid && q.deq_ready;
    // A bypassed uop is consumed directly, so it neither lands in storage nor moves a pointer
    assign wr_en    = enq_fire && !(bypass && q.deq_ready);
    assign head_adv = deq_fire && !bypass;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (reset || flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (head_adv) head_d = head_q + PTR_ONE;
            if (wr_en)    tail_d = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[tail_idx] <= q.enq_uop;
    end

    assign count = tail_q - head_q;

`ifndef SYNTHESIS
    a_depth_pow2: assert property (@(posedge clock)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
    a_count_max: assert property (@(posedge clock) disable iff (reset)
        count <= CNT_W'(DEPTH));
    a_no_enq_full: assert property (@(posedge clock) disable iff (reset)
        !(enq_fire && full));
    a_no_deq_empty: assert property (@(posedge clock) disable iff (reset)
        !(head_adv && empty));
`endif
endmodule

// File: tb/tb_uop_queue.sv
// Bench for uop_queue: table-driven directed sequences plus randomized traffic against a queue model.
module tb_uop_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 100;
`ifdef UOP_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] count;

    uop_queue_if #(.DATA_W(DW)) qif ();

    uop_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .q     (qif),
        .count (count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          ev;
        logic [31:0] pc;
        bit          dr;
        bit          fl;
        bit          rs;
        bit          er;
        bit          dv;
        int          cnt;
        bit          chk_cnt;
        bit          chk_pc;
        logic [31:0] epc;
    } vec_t;

    function automatic vec_t V(bit ev, logic [31:0] pc, bit dr, bit fl, bit rs,
                               bit er, bit dv, int cnt, bit cc, bit cp, logic [31:0] epc);
        vec_t v;
        v.ev = ev; v.pc = pc; v.dr = dr; v.fl = fl; v.rs = rs;
        v.er = er; v.dv = dv; v.cnt = cnt; v.chk_cnt = cc; v.chk_pc = cp; v.epc = epc;
        return v;
    endfunction

    function automatic logic [DW-1:0] mk(input logic [31:0] pc);
        return {4'hC, pc ^ 32'hDEADBEEF, ~pc, pc};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clock);
        reset          = v.rs;
        flush          = v.fl;
        qif.enq_valid  = v.ev;
        qif.enq_uop    = mk(v.pc);
        qif.deq_ready  = v.dr;
        #1;
        chk({tag, ".enq_ready"}, DW'(qif.enq_ready), DW'(v.er));
        chk({tag, ".deq_valid"}, DW'(qif.deq_valid), DW'(v.dv));
        if (v.chk_cnt) chk({tag, ".count"}, DW'(count), DW'(v.cnt));
        if (v.chk_pc)  chk({tag, ".deq_uop"}, qif.deq_uop, mk(v.epc));
    endtask

    task automatic run_list(input vec_t lst[$], input string tag);
        foreach (lst[i]) apply(lst[i], $sformatf("%s[%0d]", tag, i));
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    logic [DW-1:0] mq[$];
    logic [DW-1:0] cu;
    logic [DW-1:0] eu;
    bit            ev, dr, fl, rs, hold, e_er, e_dv, efire, dfire;

    initial begin
        qif.enq_valid = 1'b0;
        qif.enq_uop   = '0;
        qif.deq_ready = 1'b0;
        repeat (3) @(posedge clock);

        // Reset, fill/hold, drain, simultaneous at full, flush
        tbl.push_back(V(0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(V(1, 32'h80000000, 0, 0, 0,  1, BYP, 0, 1, BYP, 32'h80000000));
        tbl.push_back(V(1, 32'h80000004, 0, 0, 0,  1, 1, 1, 1, 1, 32'h80000000));
        tbl.push_back(V(1, 32'h80000008, 0, 0, 0,  1, 1, 2, 1, 1, 32'h80000000));
        tbl.push_back(V(1, 32'h8000000C, 0, 0, 0,  1, 1, 3, 1, 1, 32'h80000000));
        tbl.push_back(V(1, 32'h80000010, 0, 0, 0,  0, 1, 4, 1, 1, 32'h80000000));
        tbl.push_back(V(1, 32'h80000010, 0, 0, 0,  0, 1, 4, 1, 1, 32'h80000000));
        tbl.push_back(V(0, 0, 1, 0, 0,  0, 1, 4, 1, 1, 32'h80000000));
        tbl.push_back(V(0, 0, 1, 0, 0,  1, 1, 3, 1, 1, 32'h80000004));
        tbl.push_back(V(0, 0, 1, 0, 0,  1, 1, 2, 1, 1, 32'h80000008));
        tbl.push_back(V(0, 0, 1, 0, 0,  1, 1, 1, 1, 1, 32'h8000000C));
        tbl.push_back(V(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(V(1, 32'h20, 0, 0, 0,  1, BYP, 0, 1, BYP, 32'h20));
        tbl.push_back(V(1, 32'h24, 0, 0, 0,  1, 1, 1, 1, 1, 32'h20));
        tbl.push_back(V(1, 32'h28, 0, 0, 0,  1, 1, 2, 1, 1, 32'h20));
        tbl.push_back(V(1, 32'h2C, 0, 0, 0,  1, 1, 3, 1, 1, 32'h20));
        tbl.push_back(V(1, 32'h30, 1, 0, 0,  0, 1, 4, 1, 1, 32'h20));
        tbl.push_back(V(1, 32'h30, 0, 0, 0,  1, 1, 3, 1, 1, 32'h24));
        tbl.push_back(V(0, 0, 0, 0, 0,  0, 1, 4, 1, 1, 32'h24));
        tbl.push_back(V(0, 0, 1, 0, 0,  0, 1, 4, 1, 1, 32'h24));
        tbl.push_back(V(1, 32'h40, 1, 1, 0,  0, 0, 3, 1, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(V(1, 32'h100, 0, 0, 0,  1, BYP, 0, 1, BYP, 32'h100));
        tbl.push_back(V(1, 32'h104, 0, 0, 0,  1, 1, 1, 1, 1, 32'h100));
        tbl.push_back(V(0, 0, 1, 0, 0,  1, 1, 2, 1, 1, 32'h100));
        tbl.push_back(V(0, 0, 1, 0, 0,  1, 1, 1, 1, 1, 32'h104));
        tbl.push_back(V(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        run_list(tbl, "tbl");

        // Wrap-around with occupancy held at 2
        seq.delete();
        seq.push_back(V(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
        seq.push_back(V(1, 32'h300, 0, 0, 0,  1, BYP, 0, 1, BYP, 32'h300));
        seq.push_back(V(1, 32'h304, 0, 0, 0,  1, 1, 1, 1, 1, 32'h300));
        for (int i = 0; i < 6; i++)
            seq.push_back(V(1, 32'h308 + 32'(4 * i), 1, 0, 0,  1, 1, 2, 1, 1, 32'h300 + 32'(4 * i)));
        seq.push_back(V(0, 0, 1, 0, 0,  1, 1, 2, 1, 1, 32'h318));
        seq.push_back(V(0, 0, 1, 0, 0,  1, 1, 1, 1, 1, 32'h31C));
        seq.push_back(V(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        run_list(seq, "wrap");

        // Reset mid-operation, then empty-queue enqueue with deq_ready high
        seq.delete();
        seq.push_back(V(1, 32'h400, 0, 0, 0,  1, BYP, 0, 1, BYP, 32'h400));
        seq.push_back(V(1, 32'h404, 0, 0, 0,  1, 1, 1, 1, 1, 32'h400));
        seq.push_back(V(1, 32'h408, 1, 0, 1,  0, 0, 2, 0, 0, 0));
        seq.push_back(V(1, 32'h408, 1, 0, 1,  0, 0, 0, 1, 0, 0));
        seq.push_back(V(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        seq.push_back(V(1, 32'h200, 1, 0, 0,  1, BYP, 0, 1, BYP, 32'h200));
        seq.push_back(V(0, 0, 1, 0, 0,  1, !BYP, BYP ? 0 : 1, 1, !BYP, 32'h200));
        seq.push_back(V(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        run_list(seq, "rstbyp");

        // Randomized traffic against a plain queue model
        apply(V(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0), "rnd.rst");
        mq.delete();
        hold = 1'b0;
        cu   = '0;
        ev   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            rs = ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 49) == 0);
            if (!hold) begin
                ev = ($urandom_range(0, 99) < 60);
                cu = {$urandom, $urandom, $urandom, 4'($urandom)};
            end
            dr = ($urandom_range(0, 99) < 50);
            reset         = rs;
            flush         = fl;
            qif.enq_valid = ev;
            qif.enq_uop   = cu;
            qif.deq_ready = dr;
            #1;
            e_er = !rs && !fl && (mq.size() < DEPTH);
            e_dv = !rs && !fl && ((mq.size() > 0) || (BYP && ev));
            eu   = (mq.size() > 0) ? mq[0] : cu;
            chk("rnd.enq_ready", DW'(qif.enq_ready), DW'(e_er));
            chk("rnd.deq_valid", DW'(qif.deq_valid), DW'(e_dv));
            chk("rnd.count", DW'(count), DW'(mq.size()));
            if (e_dv) chk("rnd.deq_uop", qif.deq_uop, eu);
            if (rs || fl) begin
                mq.delete();
            end else begin
                efire = ev && e_er;
                dfire = e_dv && dr;
                if (!(mq.size() == 0 && efire && dfire)) begin
                    if (dfire) void'(mq.pop_front());
                    if (efire) mq.push_back(cu);
                end
            end
            hold = ev && !e_er;
        end

        @(negedge clock);
        qif.enq_valid = 1'b0;
        qif.deq_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
